// File: rtl/snn_inference_controller.sv
// Sequences one spiking-network inference per pixel: clear the datapath, run N timesteps counting spikes, hold results.
// Optional early stop on the neuron-2 count is enabled with macro SNN_CTRL_EARLY_STOP_EN.
module snn_inference_controller #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned CLEAR_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [WIDTH-1:0]  pix_data,
    input  logic [STEP_W-1:0] num_steps,
    output logic [WIDTH-1:0]  pixel_value,
    output logic              snn_rst,
    input  logic              spike_out1,
    input  logic              spike_out2,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_count1,
    output logic [CNT_W-1:0]  res_count2,
    output logic [STEP_W-1:0] res_steps,
    output logic              busy
`ifdef SNN_CTRL_EARLY_STOP_EN
    ,
    input  logic [CNT_W-1:0]  stop_count,
    output logic              res_early
`endif
);

    localparam int unsigned CLR_W = (CLEAR_CYC > 1) ? $clog2(CLEAR_CYC) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              stop_hit;
    logic [CLR_W-1:0]  clr_cnt;
    logic [STEP_W-1:0] steps_target;
    logic [CNT_W-1:0]  cnt1_inc;
    logic [CNT_W-1:0]  cnt2_inc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; counters saturate rather than wrap
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        stop_hit   = 1'b0;
        cnt1_inc   = (res_count1 == CNT_MAX) ? res_count1 : res_count1 + CNT_W'(1);
        cnt2_inc   = (res_count2 == CNT_MAX) ? res_count2 : res_count2 + CNT_W'(1);
        case (state)
            IDLE: begin
                if (pix_valid) begin
                    accept     = 1'b1;
                    state_next = (num_steps == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
`ifdef SNN_CTRL_EARLY_STOP_EN
                stop_hit = (stop_count != '0) && spike_out2 && (cnt2_inc == stop_count);
`endif
                if (((res_steps + STEP_W'(1)) == steps_target) || stop_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs track the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_ready <= 1'b1;
            busy      <= 1'b0;
            snn_rst   <= 1'b1;
            res_valid <= 1'b0;
        end else begin
            pix_ready <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            snn_rst   <= (state_next != RUN);
            res_valid <= (state_next == DONE);
        end
    end

    // Pixel latch, clear timer, step and spike counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_value  <= '0;
            steps_target <= '0;
            clr_cnt      <= '0;
            res_steps    <= '0;
            res_count1   <= '0;
            res_count2   <= '0;
        end else if (accept) begin
            pixel_value  <= pix_data;
            steps_target <= num_steps;
            clr_cnt      <= '0;
            res_steps    <= '0;
            res_count1   <= '0;
            res_count2   <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + CLR_W'(1);
        end else if (state == RUN) begin
            res_steps <= res_steps + STEP_W'(1);
            if (spike_out1) begin
                res_count1 <= cnt1_inc;
            end
            if (spike_out2) begin
                res_count2 <= cnt2_inc;
            end
        end
    end

`ifdef SNN_CTRL_EARLY_STOP_EN
    // Flags a run that ended on the neuron-2 threshold
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            res_early <= 1'b0;
        end else if (state == RUN) begin
            res_early <= stop_hit;
        end
    end
`endif

endmodule

// File: tb/tb_snn_inference_controller.sv
// Directed self-checking bench for snn_inference_controller (CNT_W=4 so saturation is reachable quickly).
module tb_snn_inference_controller;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STEP_W = 8;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              pix_valid;
    logic              pix_ready;
    logic [WIDTH-1:0]  pix_data;
    logic [STEP_W-1:0] num_steps;
    logic [WIDTH-1:0]  pixel_value;
    logic              snn_rst;
    logic              spike_out1;
    logic              spike_out2;
    logic              res_valid;
    logic              res_ready;
    logic [CNT_W-1:0]  res_count1;
    logic [CNT_W-1:0]  res_count2;
    logic [STEP_W-1:0] res_steps;
    logic              busy;
`ifdef SNN_CTRL_EARLY_STOP_EN
    logic [CNT_W-1:0]  stop_count;
    logic              res_early;
`endif

    int checks   = 0;
    int failures = 0;

    snn_inference_controller #(
        .WIDTH(WIDTH), .STEP_W(STEP_W), .CNT_W(CNT_W), .CLEAR_CYC(2)
    ) dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .num_steps(num_steps), .pixel_value(pixel_value), .snn_rst(snn_rst),
        .spike_out1(spike_out1), .spike_out2(spike_out2),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_count1(res_count1), .res_count2(res_count2), .res_steps(res_steps),
        .busy(busy)
`ifdef SNN_CTRL_EARLY_STOP_EN
        , .stop_count(stop_count), .res_early(res_early)
`endif
    );

    always #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL reset_pix_ready got=%0b exp=1", pix_ready); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid); end
        checks++; if (snn_rst !== 1'b1) begin failures++; $display("FAIL reset_snn_rst got=%0b exp=1", snn_rst); end
        checks++; if (pixel_value !== 16'h0000) begin failures++; $display("FAIL reset_pixel_value got=%0h exp=0", pixel_value); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_main_run();
        logic [9:0] s1;
        logic [9:0] s2;
        s1 = 10'b1110110110;
        s2 = 10'b1001010100;
        pix_valid = 1'b1; pix_data = 16'h1234; num_steps = 8'd10;
        tick();
        pix_valid = 1'b0; pix_data = 16'h0000; num_steps = 8'd0;
        checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL main_pix_ready got=%0b exp=0", pix_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL main_busy got=%0b exp=1", busy); end
        checks++; if (snn_rst !== 1'b1) begin failures++; $display("FAIL main_clear_snn_rst got=%0b exp=1", snn_rst); end
        tick();
        checks++; if (snn_rst !== 1'b1) begin failures++; $display("FAIL main_clear2_snn_rst got=%0b exp=1", snn_rst); end
        tick();
        checks++; if (snn_rst !== 1'b0) begin failures++; $display("FAIL main_run_snn_rst got=%0b exp=0", snn_rst); end
        for (int i = 0; i < 10; i++) begin
            spike_out1 = s1[i];
            spike_out2 = s2[i];
            if (i == 9) begin
                checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL main_early_valid got=%0b exp=0", res_valid); end
            end
            tick();
        end
        spike_out1 = 1'b0; spike_out2 = 1'b0;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL main_res_valid got=%0b exp=1", res_valid); end
        checks++; if (res_count1 !== 4'd7) begin failures++; $display("FAIL main_count1 got=%0d exp=7", res_count1); end
        checks++; if (res_count2 !== 4'd4) begin failures++; $display("FAIL main_count2 got=%0d exp=4", res_count2); end
        checks++; if (res_steps !== 8'd10) begin failures++; $display("FAIL main_steps got=%0d exp=10", res_steps); end
        checks++; if (pixel_value !== 16'h1234) begin failures++; $display("FAIL main_pixel got=%0h exp=1234", pixel_value); end
        checks++; if (snn_rst !== 1'b1) begin failures++; $display("FAIL main_done_snn_rst got=%0b exp=1", snn_rst); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++; if (pix_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++; $display("FAIL main_return_idle ready=%0b busy=%0b valid=%0b exp=1/0/0", pix_ready, busy, res_valid);
        end
    endtask

    task automatic test_zero_steps();
        spike_out1 = 1'b1; spike_out2 = 1'b1;
        pix_valid = 1'b1; pix_data = 16'hBEEF; num_steps = 8'd0;
        tick();
        pix_valid = 1'b0;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL zero_res_valid got=%0b exp=1", res_valid); end
        checks++; if (res_count1 !== 4'd0 || res_count2 !== 4'd0) begin failures++; $display("FAIL zero_counts got=%0d/%0d exp=0/0", res_count1, res_count2); end
        checks++; if (res_steps !== 8'd0) begin failures++; $display("FAIL zero_steps got=%0d exp=0", res_steps); end
        checks++; if (pixel_value !== 16'hBEEF) begin failures++; $display("FAIL zero_pixel got=%0h exp=beef", pixel_value); end
        checks++; if (snn_rst !== 1'b1) begin failures++; $display("FAIL zero_snn_rst_done got=%0b exp=1", snn_rst); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        spike_out1 = 1'b0; spike_out2 = 1'b0;
        checks++; if (snn_rst !== 1'b1 || pix_ready !== 1'b1) begin failures++; $display("FAIL zero_idle snn_rst=%0b ready=%0b exp=1/1", snn_rst, pix_ready); end
    endtask

    task automatic test_saturation();
        logic rst_dropped;
        rst_dropped = 1'b0;
        spike_out1 = 1'b1;
        pix_valid = 1'b1; pix_data = 16'h00AA; num_steps = 8'd40;
        tick();
        pix_valid = 1'b0;
        for (int i = 0; i < 41; i++) begin
            if (snn_rst == 1'b0) rst_dropped = 1'b1;
            tick();
        end
        checks++; if (rst_dropped !== 1'b1) begin failures++; $display("FAIL sat_run_entered got=%0b exp=1", rst_dropped); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL sat_early_valid got=%0b exp=0", res_valid); end
        tick();
        spike_out1 = 1'b0;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL sat_res_valid got=%0b exp=1", res_valid); end
        checks++; if (res_count1 !== 4'd15) begin failures++; $display("FAIL sat_count1 got=%0d exp=15", res_count1); end
        checks++; if (res_count2 !== 4'd0) begin failures++; $display("FAIL sat_count2 got=%0d exp=0", res_count2); end
        checks++; if (res_steps !== 8'd40) begin failures++; $display("FAIL sat_steps got=%0d exp=40", res_steps); end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        pix_valid = 1'b1; pix_data = 16'h5555; num_steps = 8'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (res_valid !== 1'b1 || pix_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold cyc=%0d valid=%0b ready=%0b exp=1/0", i, res_valid, pix_ready);
            end
            checks++; if (res_count1 !== 4'd15 || res_steps !== 8'd40 || pixel_value !== 16'h00AA) begin
                failures++; $display("FAIL bp_stable cyc=%0d c1=%0d steps=%0d pix=%0h exp=15/40/aa", i, res_count1, res_steps, pixel_value);
            end
        end
        pix_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++; if (pix_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL bp_release ready=%0b valid=%0b busy=%0b exp=1/0/0", pix_ready, res_valid, busy);
        end
        checks++; if (pixel_value !== 16'h00AA) begin failures++; $display("FAIL bp_no_accept got=%0h exp=aa", pixel_value); end
    endtask

    task automatic test_reset_mid_run();
        logic seen_valid;
        seen_valid = 1'b0;
        spike_out1 = 1'b1; spike_out2 = 1'b1;
        pix_valid = 1'b1; pix_data = 16'h0F0F; num_steps = 8'd10;
        tick();
        pix_valid = 1'b0;
        repeat (5) tick();
        checks++; if (res_steps !== 8'd3 || res_count1 !== 4'd3) begin failures++; $display("FAIL mid_pre_reset steps=%0d c1=%0d exp=3/3", res_steps, res_count1); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        spike_out1 = 1'b0; spike_out2 = 1'b0;
        checks++; if (pix_ready !== 1'b1 || busy !== 1'b0 || snn_rst !== 1'b1) begin
            failures++; $display("FAIL mid_idle ready=%0b busy=%0b snn_rst=%0b exp=1/0/1", pix_ready, busy, snn_rst);
        end
        checks++; if (res_count1 !== 4'd0 || res_count2 !== 4'd0 || res_steps !== 8'd0 || pixel_value !== 16'h0000) begin
            failures++; $display("FAIL mid_cleared c1=%0d c2=%0d steps=%0d pix=%0h exp=0", res_count1, res_count2, res_steps, pixel_value);
        end
        for (int i = 0; i < 20; i++) begin
            if (res_valid !== 1'b0) seen_valid = 1'b1;
            tick();
        end
        checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL mid_no_result got=%0b exp=0", seen_valid); end
    endtask

`ifdef SNN_CTRL_EARLY_STOP_EN
    task automatic test_early_stop();
        stop_count = 4'd2;
        spike_out2 = 1'b1;
        pix_valid = 1'b1; pix_data = 16'h0077; num_steps = 8'd10;
        tick();
        pix_valid = 1'b0;
        repeat (4) tick();
        spike_out2 = 1'b0;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL es_res_valid got=%0b exp=1", res_valid); end
        checks++; if (res_steps !== 8'd2) begin failures++; $display("FAIL es_steps got=%0d exp=2", res_steps); end
        checks++; if (res_early !== 1'b1) begin failures++; $display("FAIL es_flag got=%0b exp=1", res_early); end
        checks++; if (res_count2 !== 4'd2) begin failures++; $display("FAIL es_count2 got=%0d exp=2", res_count2); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        stop_count = 4'd0;
    endtask
`endif

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_data = '0; num_steps = '0;
        spike_out1 = 1'b0; spike_out2 = 1'b0; res_ready = 1'b0;
`ifdef SNN_CTRL_EARLY_STOP_EN
        stop_count = '0;
`endif
        #1;
        test_reset();
        test_main_run();
        test_zero_steps();
        test_saturation();
        test_backpressure();
        test_reset_mid_run();
`ifdef SNN_CTRL_EARLY_STOP_EN
        test_early_stop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snn_inference_controller.md
SNN_INFERENCE_CONTROLLER -- requirements
Module: snn_inference_controller

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16, which sets the width of the pixel path.
REQ-002 The block SHALL provide parameter STEP_W, default 8, which sets the width of the timestep count.
REQ-003 The block SHALL provide parameter CNT_W, default 8, which sets the width of each spike counter.
REQ-004 The block SHALL provide parameter CLEAR_CYC, default 2, the number of CLEAR cycles (minimum 1).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pix_valid  in  1, pix_ready  out  1, pix_data  in  WIDTH: pixel request handshake.
REQ-008 num_steps  in  STEP_W  timesteps to run; sampled at pixel accept.
REQ-009 pixel_value  out  WIDTH  pixel driven to the spike-encoder/neuron datapath.
REQ-010 snn_rst  out  1  active-high reset to the datapath.
REQ-011 spike_out1, spike_out2  in  1 each  neuron-1/neuron-2 spikes.
REQ-012 res_valid  out  1, res_ready  in  1: result handshake.
REQ-013 res_count1, res_count2  out  CNT_W each  spike totals; res_steps  out  STEP_W  timesteps actually run.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, CLEAR, RUN and DONE; all outputs SHALL decode from registers only, with no combinational input-to-output path.
REQ-016 IDLE: pix_ready=1; on pix_valid&pix_ready, latch pix_data->pixel_value and num_steps, zero counters; go CLEAR, or DONE directly if num_steps==0.
REQ-017 pix_ready SHALL be 0 in CLEAR/RUN/DONE; pix_valid there SHALL be ignored.
REQ-018 CLEAR: snn_rst=1 for exactly CLEAR_CYC cycles, then RUN.
REQ-019 RUN: snn_rst=0; each RUN cycle samples spike_out1/2 at the clock edge, adds 1 to the matching counter, and increments the step counter.
REQ-020 After num_steps RUN cycles, the FSM SHALL go to DONE; the spike present on the final RUN edge SHALL be counted.
REQ-021 The counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 snn_rst SHALL be 1 in IDLE, CLEAR and DONE.
REQ-023 DONE: res_valid=1; res_* SHALL be held stable until res_valid&res_ready, after which the FSM returns to IDLE the following cycle.
REQ-024 pixel_value SHALL hold its last accepted value until the next accept.
REQ-025 Latency SHALL be fixed: a pixel accepted at edge k gives res_valid high from edge k+CLEAR_CYC+num_steps; for num_steps=0, from edge k.
REQ-026 With num_steps==0, results SHALL be counts 0 and res_steps 0, and snn_rst SHALL never deassert.

Reset
REQ-027 When rst=1 at an edge, in any state: state->IDLE, pixel_value=0, counters=0, res_count1/2=0, res_steps=0, res_valid=0, busy=0, pix_ready=1, snn_rst=1.
REQ-028 A reset during CLEAR/RUN/DONE SHALL discard the run; no res_valid follows.

Configuration
REQ-029 With macro SNN_CTRL_EARLY_STOP_EN defined, the block SHALL add input stop_count (CNT_W) and output res_early (1): when stop_count!=0 and the neuron-2 count reaches stop_count on a RUN edge, RUN SHALL end after that edge, res_steps SHALL equal the steps run, and res_early=1.
REQ-030 Without SNN_CTRL_EARLY_STOP_EN, those ports SHALL be absent and RUN SHALL always last num_steps cycles.

Verification
REQ-031 rst held 3 cycles -> pix_ready=1, res_valid=0, snn_rst=1, pixel_value=0, busy=0.
REQ-032 pix_data=0x1234, num_steps=10, spike_out1 high on 7 RUN cycles, spike_out2 on 4 -> res_valid 12 cycles after accept, count1=7, count2=4, steps=10, pixel_value=0x1234.
REQ-033 num_steps=0 -> res_valid next cycle, counts 0, steps 0, snn_rst constantly 1.
REQ-034 CNT_W=4, spike_out1 held 1, num_steps=40 -> res_count1=15, no wrap.
REQ-035 res_ready low 5 cycles in DONE with pix_valid=1 -> results stable, pix_ready=0, no accept; res_ready=1 -> IDLE next cycle.
REQ-036 rst pulsed at RUN step 3 -> IDLE next cycle, counters 0, res_valid never asserts; with SNN_CTRL_EARLY_STOP_EN, stop_count=2 and spike_out2 held 1 -> res_steps=2, res_early=1.
